// File: rtl/clockdiv_multi_if.sv
// Configuration port for clockdiv_multi.
// Carries a valid/ready write of (channel, divide ratio, high time) and returns
// a one-cycle error pulse when an accepted write is rejected.
//   cfg_valid  master->slave  write request
//   cfg_ready  slave->master  combinational accept qualifier
//   cfg_ch     master->slave  target channel
//   cfg_div    master->slave  divide ratio
//   cfg_high   master->slave  high cycles per period
//   cfg_err    slave->master  registered reject pulse
interface clockdiv_multi_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NCH   = 4
);
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CHW-1:0]   cfg_ch;
    logic [WIDTH-1:0] cfg_div;
    logic [WIDTH-1:0] cfg_high;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_high,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_high,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/clockdiv_multi.sv
// Multi-channel programmable clock divider with glitch-free reconfiguration.
// Each channel divides clk by div_a and holds its output high for high_a cycles
// per period. New settings land in a shadow register and are applied only at a
// period boundary, on sync, or while the channel is disabled.
//   clk, rst_n  clock and asynchronous active-low reset
//   en          per-channel run enable
//   sync        restart all channel counters at phase 0
//   cfg         configuration port (slave side of clockdiv_multi_if)
//   clk_out     registered divided clocks
//   tick        registered one-cycle strobe at each period start
module clockdiv_multi #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned NCH         = 4,
    parameter int unsigned DEFAULT_DIV = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NCH-1:0]      en,
    input  logic                sync,
    clockdiv_multi_if.slave     cfg,
    output logic [NCH-1:0]      clk_out,
    output logic [NCH-1:0]      tick
);
    localparam int unsigned     CHW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(DEFAULT_DIV / 2);

    logic [WIDTH-1:0] cnt_q    [NCH];
    logic [WIDTH-1:0] cnt_d    [NCH];
    logic [WIDTH-1:0] div_a_q  [NCH];
    logic [WIDTH-1:0] div_a_d  [NCH];
    logic [WIDTH-1:0] high_a_q [NCH];
    logic [WIDTH-1:0] high_a_d [NCH];
    logic [WIDTH-1:0] div_s_q  [NCH];
    logic [WIDTH-1:0] div_s_d  [NCH];
    logic [WIDTH-1:0] high_s_q [NCH];
    logic [WIDTH-1:0] high_s_d [NCH];
    logic [NCH-1:0]   pend_q, pend_d;
    logic [NCH-1:0]   clk_q, clk_d;
    logic [NCH-1:0]   tick_q, tick_d;
    logic             err_q, err_d;

    logic [NCH-1:0]   ch_hit_c;
    logic [NCH-1:0]   term_c;
    logic             ready_c;
    logic             accept_c;
    logic             legal_c;

    // Channel decode and ready: an out-of-range channel never matches, so ready stays 1
    always_comb begin
        ch_hit_c = '0;
        ready_c  = 1'b1;
        for (int unsigned i = 0; i < NCH; i++) begin
            ch_hit_c[i] = (cfg.cfg_ch == CHW'(i));
            if (ch_hit_c[i] && pend_q[i]) begin
                ready_c = 1'b0;
            end
        end
    end

    assign cfg.cfg_ready = ready_c;
    assign cfg.cfg_err   = err_q;
    assign clk_out       = clk_q;
    assign tick          = tick_q;

    // Next-state for counters, active/shadow settings and registered outputs
    always_comb begin
        accept_c = cfg.cfg_valid && ready_c;
        legal_c  = (|ch_hit_c) && (cfg.cfg_div >= WIDTH'(2)) && (cfg.cfg_high <= cfg.cfg_div);
        err_d    = accept_c && !legal_c;
        clk_d    = '0;
        tick_d   = '0;
        term_c   = '0;
        pend_d   = pend_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            cnt_d[i]    = cnt_q[i];
            div_a_d[i]  = div_a_q[i];
            high_a_d[i] = high_a_q[i];
            div_s_d[i]  = div_s_q[i];
            high_s_d[i] = high_s_q[i];

            // >= guards against a counter left above a newly shortened period
            term_c[i] = (cnt_q[i] >= (div_a_q[i] - WIDTH'(1)));
            clk_d[i]  = en[i] && (cnt_q[i] < high_a_q[i]);
            tick_d[i] = en[i] && (cnt_q[i] == '0);

            if (sync || !en[i] || term_c[i]) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + WIDTH'(1);
            end

            // Shadow reaches the active set only at a boundary, so no short pulses
            if (pend_q[i] && (sync || !en[i] || term_c[i])) begin
                div_a_d[i]  = div_s_q[i];
                high_a_d[i] = high_s_q[i];
                pend_d[i]   = 1'b0;
            end

            // Accept implies !pend_q, so this never collides with the apply above
            if (accept_c && legal_c && ch_hit_c[i]) begin
                div_s_d[i]  = cfg.cfg_div;
                high_s_d[i] = cfg.cfg_high;
                pend_d[i]   = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i]    <= '0;
                div_a_q[i]  <= RST_DIV;
                high_a_q[i] <= RST_HIGH;
                div_s_q[i]  <= RST_DIV;
                high_s_q[i] <= RST_HIGH;
            end
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                div_a_q[i]  <= div_a_d[i];
                high_a_q[i] <= high_a_d[i];
                div_s_q[i]  <= div_s_d[i];
                high_s_q[i] <= high_s_d[i];
            end
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
            err_q  <= err_d;
        end
    end
endmodule
